// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared line-level memory interface widths, responder states and defaults
package mem_if_pkg;
    localparam int ADDR_W          = 28;
    localparam int DATA_W          = 128;
    localparam int DEPTH_LOG2_DEF  = 8;
    localparam int LATENCY_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;
endpackage

// File: rtl/mem_line_responder_if.sv
// rtl/mem_line_responder_if.sv - L2-to-memory line request/ready bundle
interface mem_line_responder_if;
    import mem_if_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - line backing store with one synchronous read/write port
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] store [DEPTH];

    // rdata only moves on a read, so it doubles as the held response line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                store[idx] <= wdata;
            end
            if (re) begin
                rdata <= store[idx];
            end
        end
    end
endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency line memory responder with protocol-error detection
module mem_line_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_line_responder_if.slave  bus,
    output logic                 proto_err,
    output logic [15:0]          rd_cnt,
    output logic [15:0]          wr_cnt
);
    resp_state_t       state, next_state;
    logic [7:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;

    logic accept, abort, commit, both_req, req_ok;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        abort      = 1'b0;
        commit     = 1'b0;
        both_req   = 1'b0;
        req_ok     = op_wr ? (bus.mem_write && !bus.mem_read)
                           : (bus.mem_read && !bus.mem_write);
        case (state)
            IDLE: begin
                if (bus.mem_read && bus.mem_write) begin
                    both_req = 1'b1;
                end else if (bus.mem_read || bus.mem_write) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                // the held request must match what was accepted on every edge
                if (!req_ok || (bus.mem_addr != addr_q)) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (cnt == 8'd0) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            proto_err <= 1'b0;
            rd_cnt    <= 16'd0;
            wr_cnt    <= 16'd0;
        end else begin
            state     <= next_state;
            ready_q   <= commit;
            proto_err <= proto_err | both_req | abort;
            if (accept) begin
                op_wr   <= bus.mem_write;
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                cnt     <= 8'(LATENCY - 1);
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (commit && op_wr) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (commit && !op_wr) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

    mem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (commit && op_wr),
        .re    (commit && !op_wr),
        .idx   (addr_q[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .rdata (bus.mem_rdata)
    );

    assign bus.mem_ready = ready_q;
endmodule
